// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stage registers: slot state
// encoding, stage payload widths and small state-decode helpers.
package pipe_pkg;

   // Occupancy of a stage register: no live word, main live, main+skid live.
   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_FULL  = 2'd1,
      PS_SKID  = 2'd2
   } pipe_state_t;

   // Packed stage bundle widths for a 32-bit core.
   // F/D: pc + instruction word.
   localparam int FD_PAYLOAD_W = 64;
   // D/E: pc + rs1 value + rs2 value + immediate + control bits.
   localparam int DE_PAYLOAD_W = 32 + 32 + 32 + 32 + 16;
   // E/M: alu result + store data + rd index + control bits.
   localparam int EM_PAYLOAD_W = 32 + 32 + 5 + 8;
   // M/W: writeback value + rd index + write enable.
   localparam int MW_PAYLOAD_W = 32 + 5 + 1;

   // A word is presented downstream whenever the main slot is live.
   function automatic logic state_live(input pipe_state_t s);
      return (s != PS_EMPTY);
   endfunction

   // Only the skid state has no free slot for an incoming word.
   function automatic logic state_can_accept(input pipe_state_t s);
      return (s != PS_SKID);
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload slot of a stage register: a DATA_WIDTH register with a
// synchronous clear (wins over load) and a load enable.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;

   // Next slot contents: clear beats load, otherwise hold.
   always_comb begin
      data_d = data_q;
      if (clr) begin
         data_d = '0;
      end else if (load) begin
         data_d = d;
      end
   end

   // Slot storage.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with a 2-entry skid buffer, synchronous
// flush and a saturating stall counter.
//
// Handshake: a word moves on a rising edge when valid and ready are both 1
// in the preceding cycle. in_ready is a function of registered state and
// flush only (never of out_ready), so back-pressure does not form a
// combinational path across the stage. Once out_valid is 1 the word on
// out_data stays put until it is drained or flushed.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int CLEAR_ON_FLUSH = 1,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [1:0]            dbg_state
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   pipe_state_t           state_q;
   pipe_state_t           state_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q;
   logic [CNT_WIDTH-1:0]  stall_cnt_d;

   logic                  accept;
   logic                  drain;
   logic                  main_load;
   logic                  main_sel_skid;
   logic                  skid_load;
   logic                  slot_clr;
   logic [DATA_WIDTH-1:0] main_in;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] skid_q;

   // Handshake decode from registered state; flush blocks new words.
   always_comb begin
      in_ready  = state_can_accept(state_q) & ~flush;
      out_valid = state_live(state_q);
      accept    = in_valid & in_ready;
      drain     = out_valid & out_ready;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flush empties the stage, otherwise follow accept/drain.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = PS_EMPTY;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (accept) state_d = PS_FULL;
            end
            PS_FULL: begin
               if (accept && !drain) begin
                  state_d = PS_SKID;
               end else if (!accept && drain) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_SKID: begin
               if (drain) state_d = PS_FULL;
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   // Slot control: which slot loads and from where. A flush suppresses all
   // loads, so with clearing disabled the slots keep their old contents.
   always_comb begin
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      if (!flush) begin
         case (state_q)
            PS_EMPTY: begin
               main_load = accept;
            end
            PS_FULL: begin
               main_load = accept & drain;
               skid_load = accept & ~drain;
            end
            PS_SKID: begin
               main_load     = drain;
               main_sel_skid = 1'b1;
            end
            default: begin
               main_load = 1'b0;
            end
         endcase
      end
   end

   // Slot clear and main-slot source select.
   always_comb begin
      slot_clr = rst | (flush & (CLEAR_ON_FLUSH != 0));
      main_in  = main_sel_skid ? skid_q : in_data;
   end

   pipe_slot #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_main_slot (
      .clk  (clk),
      .clr  (slot_clr),
      .load (main_load),
      .d    (main_in),
      .q    (main_q)
   );

   pipe_slot #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid_slot (
      .clk  (clk),
      .clr  (slot_clr),
      .load (skid_load),
      .d    (in_data),
      .q    (skid_q)
   );

   // Stall counter: a live word refused by downstream, ignoring flush
   // cycles; sticks at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_data  = main_q;
   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register placed between any two CPU stages (F/D, D/E, E/M, M/W) as the generalised replacement for fixed, always-loading stage registers. Carries an arbitrary-width payload with valid/ready handshaking, a 2-entry skid buffer so upstream can be back-pressured without a combinational ready path, and a synchronous flush for branch/jump squash. A saturating stall counter supports performance analysis.

## Interface
- DATA_WIDTH, 32: payload width in bits; a stage bundle is packed into one vector.
- CLEAR_ON_FLUSH, 1: 1 zeroes the payload slots on reset/flush (bubble = all-zero payload); 0 leaves payload contents unchanged.
- CNT_WIDTH, 16: width of stall counter.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held entries; highest priority after rst.
- in_valid  in  1  upstream presents a word.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live word.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  DATA_WIDTH  payload from main slot.
- stall_cnt  out  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Two slots: main (drives out_data) and skid. States: EMPTY (none live), FULL (main live), SKID (main and skid live).
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> main<=in_data, go FULL.
- FULL: accept & drain -> main<=in_data, stay FULL; accept & !drain -> skid<=in_data, go SKID; !accept & drain -> go EMPTY; else hold.
- SKID: drain -> main<=skid, go FULL; else hold. No accept possible in SKID.
- in_ready = (state != SKID) & !flush. out_valid = (state != EMPTY). out_data = main, regardless of state.
- flush=1: next state EMPTY; any concurrent accept or drain is discarded (drain still counts as taken by downstream; the word is not replayed). CLEAR_ON_FLUSH=1 zeroes main and skid.
- rst=1: state EMPTY, main=skid=0 (independent of CLEAR_ON_FLUSH), stall_cnt=0. rst overrides flush.
- stall_cnt increments each cycle out_valid & !out_ready & !flush; saturates at 2^CNT_WIDTH-1; cleared only by rst.
- Ordering: words leave in exact acceptance order; no loss or duplication except on flush.

## Timing
- Reset values: in_ready=1 (when flush=0), out_valid=0, out_data=0, stall_cnt=0.
- Latency: word accepted at edge N appears on out_data with out_valid=1 in the cycle after edge N (1 cycle).
- Throughput: 1 word/cycle with out_ready held high.
- in_ready depends only on registered state and flush; no combinational path from out_ready to in_ready.
- out_ready drop in FULL with in_valid=1: that word goes to skid, in_ready=0 the following cycle; out_ready returning: skid word on out_data 1 cycle later, in_ready=1 again the same cycle.
- Flush during SKID: both words discarded; out_valid=0 and in_ready=1 the next cycle.

## Structure
- Shared package pipe_pkg: typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_t; stage payload packing widths (e.g. DE_PAYLOAD_W) as localparams.
- One sub-module pipe_slot: DATA_WIDTH register with synchronous clear and load enable, instantiated twice (main, skid).
- Top holds state machine, handshake logic and stall counter.

## Test plan
- Reset: rst high 2 cycles -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0.
- Streaming: in_valid=1, data 1,2,3,4 consecutive, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, one cycle after each accept.
- Back-pressure: stream 0xA,0xB,0xC, out_ready=0 after 0xA appears -> 0xB held in skid, in_ready=0, 0xC held upstream; out_ready=1 -> out 0xA,0xB,0xC in order, no loss; stall_cnt equals stalled cycles.
- Flush in SKID with CLEAR_ON_FLUSH=1: flush 1 cycle -> next cycle out_valid=0, out_data=0, in_ready=1; subsequent 0x55 emerges alone.
- Flush plus concurrent accept: in_valid=1 data 0x77 with flush=1 -> 0x77 never appears; in_ready reads 0 that cycle.
- Counter saturation with CNT_WIDTH=4: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
